// File: rtl/store_router_if.sv
// Store-side bus between the memory stage and store_router, plus the
// UART transmit byte stream that leaves the router.
// master: core/environment side, slave: store_router side.
interface store_router_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic [31:0] pc;
    logic        stall;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_space;

    modport master (
        output st_valid, st_addr, st_data, st_funct3, pc, tx_ready,
        input  stall, tx_data, tx_valid, tx_space
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, pc, tx_ready,
        output stall, tx_data, tx_valid, tx_space
    );
endinterface

// File: rtl/store_router.sv
// store_router: decodes a memory-stage store and routes it to DMEM, IMEM
// (only while executing from BIOS) or the memory-mapped UART TX / counter
// reset registers. UART bytes are queued in a small FIFO; a store to a full
// FIFO is held with stall.
// Optional feature macro: STORE_ROUTER_MISALIGN_TRAP_EN suppresses
// misaligned SH/SW stores and adds a sticky misalign_err output.
module store_router #(
    parameter int TX_FIFO_DEPTH = 4,
    parameter int DMEM_AW       = 14,
    parameter int IMEM_AW       = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    store_router_if.slave      st,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    output logic [3:0]         imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din,
    output logic               cnt_reset
`ifdef STORE_ROUTER_MISALIGN_TRAP_EN
    ,
    output logic               misalign_err
`endif
);
    localparam int PW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TX_FIFO_DEPTH);

    localparam logic [31:0] UART_TX_ADDR = 32'h8000_0008;
    localparam logic [31:0] CNT_RST_ADDR = 32'h8000_0018;

    logic [3:0]  region;
    logic        is_dmem, is_imem, is_uart, is_cntr;
    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic        suppress;
    logic        wr_ok;
    logic        push, pop;

    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // Only pc[30] (BIOS execution) matters for routing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{st.pc[31], st.pc[29:0]};

    assign region  = st.st_addr[31:28];
    assign is_dmem = (region[3:2] == 2'b00) && region[0];
    assign is_imem = (region[3:1] == 3'b001) && st.pc[30];
    assign is_uart = (st.st_addr == UART_TX_ADDR);
    assign is_cntr = (st.st_addr == CNT_RST_ADDR);

`ifdef STORE_ROUTER_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((st.st_funct3 == 3'b001) && st.st_addr[0]) ||
                        ((st.st_funct3 == 3'b010) && (st.st_addr[1:0] != 2'b00));
    assign suppress   = misaligned;
`else
    // Misaligned halves/words simply land on the aligned-down location.
    assign suppress   = 1'b0;
`endif

    // Byte enables and lane-replicated write data from funct3 and the low address bits.
    always_comb begin
        lane_we  = 4'b0000;
        lane_din = st.st_data;
        case (st.st_funct3)
            3'b000: begin
                lane_we  = 4'b0001 << st.st_addr[1:0];
                lane_din = {4{st.st_data[7:0]}};
            end
            3'b001: begin
                lane_we  = 4'b0011 << {st.st_addr[1], 1'b0};
                lane_din = {2{st.st_data[15:0]}};
            end
            3'b010: begin
                lane_we  = 4'b1111;
                lane_din = st.st_data;
            end
            default: lane_we = 4'b0000;
        endcase
    end

    // stall depends only on the store and FIFO occupancy, never on tx_ready.
    assign st.stall = st.st_valid && is_uart && (count == FULL);
    assign wr_ok    = st.st_valid && !st.stall && !suppress;

    assign dmem_we   = (wr_ok && is_dmem) ? lane_we : 4'b0000;
    assign imem_we   = (wr_ok && is_imem) ? lane_we : 4'b0000;
    assign dmem_din  = lane_din;
    assign imem_din  = lane_din;
    assign dmem_addr = st.st_addr[DMEM_AW+1:2];
    assign imem_addr = st.st_addr[IMEM_AW+1:2];

    assign push = wr_ok && is_uart;
    assign pop  = st.tx_valid && st.tx_ready;

    assign st.tx_valid = (count != '0);
    assign st.tx_space = (count != FULL);
    assign st.tx_data  = fifo_mem[rd_ptr];

    // UART TX FIFO storage and pointers; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= st.st_data[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One-cycle counter reset pulse following each store to the counter-reset address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reset <= 1'b0;
        else        cnt_reset <= st.st_valid && is_cntr && !suppress;
    end

`ifdef STORE_ROUTER_MISALIGN_TRAP_EN
    // Sticky flag: set by any presented misaligned SH/SW, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         misalign_err <= 1'b0;
        else if (st.st_valid && misaligned) misalign_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_store_router.sv
// Self-checking bench for store_router: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// byte-lane / queue model of the routing and UART FIFO rules.
module tb_store_router;
    localparam int DEPTH = 4;
    localparam int DAW   = 14;
    localparam int IAW   = 14;
    localparam logic [31:0] UART = 32'h8000_0008;
    localparam logic [31:0] CNTR = 32'h8000_0018;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_router_if bus();
    logic [3:0]     dmem_we, imem_we;
    logic [DAW-1:0] dmem_addr;
    logic [IAW-1:0] imem_addr;
    logic [31:0]    dmem_din, imem_din;
    logic           cnt_reset;
`ifdef STORE_ROUTER_MISALIGN_TRAP_EN
    logic           misalign_err;
`endif

    store_router #(.TX_FIFO_DEPTH(DEPTH), .DMEM_AW(DAW), .IMEM_AW(IAW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st        (bus.slave),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_din  (dmem_din),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din),
        .cnt_reset (cnt_reset)
`ifdef STORE_ROUTER_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    bit         exp_cnt = 1'b0;
    bit         exp_mis = 1'b0;

    always @(negedge clk) begin : cmp
        logic [3:0]  e_we;
        logic [31:0] e_din;
        logic [3:0]  reg_n;
        bit uart, cntr, dm, im, e_stall, supp, ok, push, pop;
        if (!rst_n) begin
            q.delete();
            exp_cnt = 1'b0;
            exp_mis = 1'b0;
        end
        reg_n = bus.st_addr[31:28];
        uart  = (bus.st_addr == UART);
        cntr  = (bus.st_addr == CNTR);
        dm    = (reg_n == 4'h1) || (reg_n == 4'h3);
        im    = ((reg_n == 4'h2) || (reg_n == 4'h3)) && bus.pc[30];
        e_we  = 4'b0;
        e_din = 32'b0;
        for (int i = 0; i < 4; i++) begin
            case (bus.st_funct3)
                3'd0: begin
                    e_we[i] = (i == int'(bus.st_addr[1:0]));
                    e_din[8*i +: 8] = bus.st_data[7:0];
                end
                3'd1: begin
                    e_we[i] = ((i / 2) == int'(bus.st_addr[1]));
                    e_din[8*i +: 8] = bus.st_data[8*(i%2) +: 8];
                end
                3'd2: begin
                    e_we[i] = 1'b1;
                    e_din[8*i +: 8] = bus.st_data[8*i +: 8];
                end
                default: e_we[i] = 1'b0;
            endcase
        end
        supp = 1'b0;
`ifdef STORE_ROUTER_MISALIGN_TRAP_EN
        begin
            bit mis;
            mis  = ((bus.st_funct3 == 3'd1) && bus.st_addr[0]) ||
                   ((bus.st_funct3 == 3'd2) && (bus.st_addr[1:0] != 2'b00));
            supp = mis;
            chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
            if (rst_n && bus.st_valid && mis) exp_mis = 1'b1;
        end
`endif
        e_stall = bus.st_valid && uart && (q.size() == DEPTH);
        ok      = bus.st_valid && !e_stall && !supp;

        chk("dmem_we",   32'(dmem_we),   32'((ok && dm) ? e_we : 4'b0));
        chk("imem_we",   32'(imem_we),   32'((ok && im) ? e_we : 4'b0));
        chk("dmem_addr", 32'(dmem_addr), (bus.st_addr >> 2) & ((32'd1 << DAW) - 1));
        chk("imem_addr", 32'(imem_addr), (bus.st_addr >> 2) & ((32'd1 << IAW) - 1));
        if (bus.st_funct3 <= 3'd2) begin
            chk("dmem_din", dmem_din, e_din);
            chk("imem_din", imem_din, e_din);
        end
        chk("stall",     32'(bus.stall),    32'(e_stall));
        chk("tx_valid",  32'(bus.tx_valid), 32'(q.size() != 0));
        chk("tx_space",  32'(bus.tx_space), 32'(q.size() < DEPTH));
        if (q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
        chk("cnt_reset", 32'(cnt_reset), 32'(exp_cnt));

        // Advance the model to the state after the coming rising edge.
        if (rst_n) begin
            pop  = (q.size() != 0) && bus.tx_ready;
            push = bus.st_valid && uart && !e_stall && !supp;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(bus.st_data[7:0]);
            exp_cnt = bus.st_valid && cntr && !supp;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] p, input bit rdy);
        @(posedge clk);
        #1;
        bus.st_valid  = v;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.st_funct3 = f;
        bus.pc        = p;
        bus.tx_ready  = rdy;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 32'h0, rdy);
    endtask

    initial begin
        bus.st_valid  = 1'b0;
        bus.st_addr   = 32'h0;
        bus.st_data   = 32'h0;
        bus.st_funct3 = 3'd0;
        bus.pc        = 32'h0;
        bus.tx_ready  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst tx_valid",  32'(bus.tx_valid), 32'd0);
        chk("rst tx_data",   32'(bus.tx_data),  32'd0);
        chk("rst tx_space",  32'(bus.tx_space), 32'd1);
        chk("rst stall",     32'(bus.stall),    32'd0);
        chk("rst cnt_reset", 32'(cnt_reset),    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // SB into DMEM
        drive(1'b1, 32'h1000_0006, 32'hAABB_CCDD, 3'd0, 32'h0, 1'b0);
        #2;
        chk("sb dmem_we",   32'(dmem_we),   32'h4);
        chk("sb dmem_din",  dmem_din,       32'hDDDD_DDDD);
        chk("sb dmem_addr", 32'(dmem_addr), 32'd1);
        chk("sb imem_we",   32'(imem_we),   32'd0);

        // SW into IMEM only while executing from BIOS
        drive(1'b1, 32'h2000_0010, 32'h1234_5678, 3'd2, 32'h4000_0000, 1'b0);
        #2;
        chk("sw imem_we bios", 32'(imem_we),   32'hF);
        chk("sw imem_addr",    32'(imem_addr), 32'd4);
        chk("sw dmem_we",      32'(dmem_we),   32'd0);
        drive(1'b1, 32'h2000_0010, 32'h1234_5678, 3'd2, 32'h0000_1000, 1'b0);
        #2;
        chk("sw imem_we user", 32'(imem_we), 32'd0);

        // Fill the UART FIFO, stall on the fifth byte, release by one pop
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, UART, 32'(k), 3'd0, 32'h0, 1'b0);
            #2;
            chk("fill stall", 32'(bus.stall), 32'd0);
            chk("fill tx_space", 32'(bus.tx_space), 32'd1);
        end
        drive(1'b1, UART, 32'd5, 3'd0, 32'h0, 1'b0);
        #2;
        chk("full tx_space", 32'(bus.tx_space), 32'd0);
        chk("full stall",    32'(bus.stall),    32'd1);
        chk("full tx_data",  32'(bus.tx_data),  32'd1);
        drive(1'b1, UART, 32'd5, 3'd0, 32'h0, 1'b1);
        #2;
        chk("pop-cycle stall", 32'(bus.stall), 32'd1);
        drive(1'b1, UART, 32'd5, 3'd0, 32'h0, 1'b0);
        #2;
        chk("retry stall",   32'(bus.stall),   32'd0);
        chk("retry tx_data", 32'(bus.tx_data), 32'd2);
        for (int k = 2; k <= 5; k++) begin
            idle(1'b1);
            #2;
            chk("drain tx_valid", 32'(bus.tx_valid), 32'd1);
            chk("drain tx_data",  32'(bus.tx_data),  32'(k));
        end
        idle(1'b0);
        #2;
        chk("drained tx_valid", 32'(bus.tx_valid), 32'd0);

        // Simultaneous push and pop at count 2
        drive(1'b1, UART, 32'h11, 3'd0, 32'h0, 1'b0);
        drive(1'b1, UART, 32'h22, 3'd0, 32'h0, 1'b0);
        drive(1'b1, UART, 32'h33, 3'd0, 32'h0, 1'b1);
        #2;
        chk("pp head before", 32'(bus.tx_data), 32'h11);
        idle(1'b0);
        #2;
        chk("pp head after", 32'(bus.tx_data),  32'h22);
        chk("pp tx_space",   32'(bus.tx_space), 32'd1);
        idle(1'b1);
        #2;
        chk("pp drain0", 32'(bus.tx_data), 32'h22);
        idle(1'b1);
        #2;
        chk("pp drain1", 32'(bus.tx_data), 32'h33);
        idle(1'b0);
        #2;
        chk("pp empty", 32'(bus.tx_valid), 32'd0);

        // Counter reset pulses
        drive(1'b1, CNTR, 32'hFFFF_FFFF, 3'd2, 32'h0, 1'b0);
        #2;
        chk("cnt before edge", 32'(cnt_reset), 32'd0);
        idle(1'b0);
        #2;
        chk("cnt pulse", 32'(cnt_reset), 32'd1);
        idle(1'b0);
        #2;
        chk("cnt cleared", 32'(cnt_reset), 32'd0);
        drive(1'b1, CNTR, 32'h0, 3'd0, 32'h0, 1'b0);
        drive(1'b1, CNTR, 32'h0, 3'd5, 32'h0, 1'b0);
        #2;
        chk("cnt b2b 0", 32'(cnt_reset), 32'd1);
        idle(1'b0);
        #2;
        chk("cnt b2b 1", 32'(cnt_reset), 32'd1);
        idle(1'b0);
        #2;
        chk("cnt b2b end", 32'(cnt_reset), 32'd0);

        // BIOS address range is dropped
        drive(1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 3'd2, 32'h4000_0000, 1'b0);
        #2;
        chk("bios dmem_we", 32'(dmem_we), 32'd0);
        chk("bios imem_we", 32'(imem_we), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            logic [31:0] p;
            case ($urandom_range(0, 7))
                0, 1: a = UART;
                2:    a = CNTR;
                3:    a = {4'h1, 28'($urandom)};
                4:    a = {4'h2, 28'($urandom)};
                5:    a = {4'h3, 28'($urandom)};
                6:    a = {4'h4, 28'($urandom)};
                default: a = $urandom;
            endcase
            f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            p = $urandom;
            drive($urandom_range(0, 9) < 7, a, $urandom, f, p, $urandom_range(0, 9) < 4);
        end

        // Asynchronous reset with three bytes queued
        for (int k = 0; k < 6; k++) idle(1'b1);
        drive(1'b1, UART, 32'hA1, 3'd0, 32'h0, 1'b0);
        drive(1'b1, UART, 32'hA2, 3'd0, 32'h0, 1'b0);
        drive(1'b1, UART, 32'hA3, 3'd0, 32'h0, 1'b0);
        drive(1'b1, CNTR, 32'h0, 3'd2, 32'h0, 1'b0);
        idle(1'b0);
        #2;
        chk("pre-rst tx_valid",  32'(bus.tx_valid), 32'd1);
        chk("pre-rst cnt_reset", 32'(cnt_reset),    32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async tx_valid",  32'(bus.tx_valid), 32'd0);
        chk("async tx_space",  32'(bus.tx_space), 32'd1);
        chk("async cnt_reset", 32'(cnt_reset),    32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_router.md
Name: store_router

Overview:
- Store-side counterpart of the core's writeback/load path: accepts a store from the memory stage and routes it to DMEM, IMEM or memory-mapped IO.
- Generates byte enables and lane-replicated write data for the RAMs.
- Buffers UART transmit bytes in a small FIFO drained to the UART transmitter over ready/valid.
- Issues a stall when the FIFO cannot accept a byte, and pulses the cycle-counter reset.

Parameters:
TX_FIFO_DEPTH, 4, UART TX byte FIFO entries (power of 2, >=2)
DMEM_AW, 14, DMEM word-address width
IMEM_AW, 14, IMEM word-address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  store present this cycle
st_addr  in  32  byte address
st_data  in  32  unshifted rs2 value
st_funct3  in  3  000 SB, 001 SH, 010 SW
pc  in  32  PC of the storing instruction
dmem_we  out  4  DMEM byte enables
dmem_addr  out  DMEM_AW  st_addr[DMEM_AW+1:2]
dmem_din  out  32  lane-replicated data
imem_we  out  4  IMEM byte enables
imem_addr  out  IMEM_AW  st_addr[IMEM_AW+1:2]
imem_din  out  32  lane-replicated data
tx_data  out  8  FIFO head byte to UART TX
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  UART TX accepts byte
tx_space  out  1  FIFO not full; feeds UART control status read
stall  out  1  hold pipeline; store not accepted
cnt_reset  out  1  one-cycle cycle/instr counter reset pulse

Behaviour:
- Decode on st_addr[31:28]:
  - DMEM when 4'b00x1.
  - IMEM when 4'b001x and pc[30]==1 (executing from BIOS).
  - 0x3xxxxxxx with pc[30]==1 writes both DMEM and IMEM.
  - IO: exact 0x80000008 is UART TX; exact 0x80000018 is counter reset.
  - All other addresses, BIOS (0x4xxxxxxx) included, are dropped silently.
- Byte enables and data:
  - SB: we=4'b0001<<addr[1:0], din={4{data[7:0]}}.
  - SH: we=4'b0011<<{addr[1],1'b0}, din={2{data[15:0]}}.
  - SW: we=4'b1111, din=data.
  - Any other funct3: we=0.
- RAM outputs are combinational from st_*. we=0 when st_valid=0 or stall=1.
- UART FIFO:
  - stall = st_valid & UART address & count==TX_FIFO_DEPTH.
  - stall is combinational but independent of tx_ready, so there is no ready-to-stall path.
  - Push st_data[7:0] on the rising edge when st_valid & UART address & !stall.
  - Pop when tx_valid & tx_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - A pop from a full FIFO frees a slot for the next cycle only; stall stays high in the pop cycle.
  - Pointers wrap modulo TX_FIFO_DEPTH.
  - tx_data is the registered head entry.
  - tx_valid = count!=0.
  - tx_space = count<TX_FIFO_DEPTH.
- Counter reset: a store to 0x80000018 (any funct3, data ignored) registers cnt_reset=1 for exactly the next cycle. Back-to-back stores give back-to-back pulses.
- Reset values: count=0, pointers=0, tx_valid=0, tx_data=0, cnt_reset=0, tx_space=1, stall=0.
- Reset mid-operation: FIFO contents discarded; any pending cnt_reset is cancelled.

Optional Feature:
- Macro: STORE_ROUTER_MISALIGN_TRAP_EN.
- Defined:
  - A SH with addr[0]=1 or a SW with addr[1:0]!=0 is suppressed: all we=0, no FIFO push, no cnt_reset.
  - Adds output port misalign_err (1 bit), which sets sticky on the edge of the offending store and clears only on reset.
- Undefined:
  - Port absent.
  - Misaligned stores use the formulas above with low bits ignored (SH uses addr[1], SW is full word), writing the aligned-down location.

Test Plan:
- SB 0xAABBCCDD to 0x10000006 -> dmem_we=4'b0100, dmem_din=0xDDDDDDDD, dmem_addr=1, imem_we=0.
- SW 0x12345678 to 0x20000010 with pc=0x40000000 -> imem_we=4'hF, imem_addr=4; same store with pc=0x00001000 -> imem_we=0.
- Five SB to 0x80000008 (bytes 1..5) with tx_ready=0, DEPTH=4:
  - tx_space falls after the 4th byte.
  - The 5th byte holds stall=1.
  - Raising tx_ready pops 1, and the next cycle pushes 5 with stall low.
  - Drain order is 1,2,3,4,5.
- Push and pop in the same cycle at count=2 -> count stays 2; tx_data advances to the next byte.
- SW to 0x80000018 -> cnt_reset high for exactly one cycle after the store edge; stores to 0x4000_0000 produce no enables.
- Assert rst_n=0 mid-cycle with 3 bytes queued -> tx_valid=0, tx_space=1 immediately, with no clock edge needed.
